// File: rtl/mem_ctrl.sv
// Burst memory controller: accepts read/write bursts of 1..16 beats and drives a
// registered synchronous memory interface with a shared tri-state data bus.
module mem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_rw
);

  // Handshakes: a request transfers on a clock edge where req_valid && req_ready,
  // a write beat on an edge where wr_valid && wr_ready; rd_valid has no backpressure.

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [3:0]            beat_cnt;
  logic [3:0]            len_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mem_oe;
  logic                  rd_pend;
  logic                  req_fire;
  logic                  wr_fire;
  logic                  last_beat;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign wr_ready  = (state == WRITE);
  assign req_fire  = req_valid && req_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign last_beat = (beat_cnt == len_q);

  assign mem_data = mem_oe ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire) state_nxt = req_rw ? WRITE : READ;
      WRITE:   if (wr_fire && last_beat) state_nxt = IDLE;
      READ:    if (last_beat) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs are all registered; a read burst issues beat 0 on the
  // accepting edge so beat i is on the bus in the i-th cycle after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_cs   <= 1'b0;
      mem_rw   <= 1'b0;
      mem_oe   <= 1'b0;
      mem_addr <= '0;
      wdata_q  <= '0;
      cur_addr <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= mem_cs && !mem_rw;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= mem_data;
      mem_cs <= 1'b0;
      mem_rw <= 1'b0;
      mem_oe <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            len_q    <= req_len;
            beat_cnt <= '0;
            if (req_rw) begin
              cur_addr <= req_addr;
            end else begin
              mem_cs   <= 1'b1;
              mem_addr <= req_addr;
              cur_addr <= req_addr + 1'b1;
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            mem_cs   <= 1'b1;
            mem_rw   <= 1'b1;
            mem_oe   <= 1'b1;
            mem_addr <= cur_addr;
            wdata_q  <= wr_data;
            cur_addr <= cur_addr + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        READ: begin
          if (!last_beat) begin
            mem_cs   <= 1'b1;
            mem_addr <= cur_addr;
            cur_addr <= cur_addr + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: table of bursts with expected timing, a behavioural
// synchronous memory, and scoreboards for memory write beats and read returns.
module tb_mem_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [3:0]    req_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs;
  logic          mem_rw;

  always #5 clk = ~clk;

  mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_cs(mem_cs), .mem_rw(mem_rw)
  );

  // Synchronous memory: address registered on the edge after the beat, data
  // returned during the following cycle.
  logic [DW-1:0] mem_arr [256];
  logic          mem_inited = 1'b0;
  logic          rd_en_q = 1'b0;
  logic [AW-1:0] rd_addr_q = '0;

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= DW'(i * 7 + 3);
      mem_inited <= 1'b1;
    end else if (mem_cs && mem_rw) begin
      mem_arr[mem_addr] <= mem_data;
    end
    rd_en_q   <= mem_cs && !mem_rw;
    rd_addr_q <= mem_addr;
  end

  assign mem_data = rd_en_q ? mem_arr[rd_addr_q] : {DW{1'bz}};

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected none (t=%0t)", name, act, $time);
  endtask

  // Scoreboard state
  logic [15:0] exp_w[$];
  logic [7:0]  exp_r[$];
  logic [DW-1:0] ref_mem [256];
  int cyc = 0;
  int busy_cnt = 0;
  int wbeat_cnt = 0;
  int rv_cnt = 0;
  int first_cyc = -1;
  int last_rv_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset) begin
      if (busy) busy_cnt++;
      check("oe_only_on_write_beat", {31'd0, dut.mem_oe}, {31'd0, mem_cs && mem_rw});
      check("ready_vs_busy", {31'd0, req_ready}, {31'd0, !busy});
      if (mem_cs && mem_rw) begin
        wbeat_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        if (exp_w.size() == 0) fail_event("unexpected_write_beat", {24'd0, mem_addr});
        else begin
          logic [15:0] e;
          e = exp_w.pop_front();
          check("write_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
          check("write_data", {24'd0, mem_data}, {24'd0, e[7:0]});
        end
      end
      if (rd_valid) begin
        rv_cnt++;
        last_rv_cyc = cyc;
        if (first_cyc < 0) first_cyc = cyc;
        if (exp_r.size() == 0) fail_event("unexpected_rd_valid", {24'd0, rd_data});
        else check("rd_data", {24'd0, rd_data}, {24'd0, exp_r.pop_front()});
      end
    end
  end

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [3:0] len;
    logic       gap;
    logic [7:0] base;
    int         exp_busy;
    int         exp_lat;
    int         exp_beats;
  } vec_t;

  vec_t vecs[12];

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) fail_event("req_ready_timeout", {31'd0, req_ready});
  endtask

  task automatic wait_busy_fall(output int fall_cyc);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 100);
    fall_cyc = cyc;
    check("busy_fall_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_burst(input vec_t v);
    int acc_cyc, fall_cyc, beat, k;
    logic [7:0] a;
    wait_ready();
    req_valid = 1'b1;
    req_rw    = v.rw;
    req_addr  = v.addr;
    req_len   = v.len;
    if (!v.rw)
      for (int i = 0; i <= int'(v.len); i++) begin
        a = v.addr + 8'(i);
        exp_r.push_back(ref_mem[a]);
      end
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc_cyc = cyc; busy_cnt = 0; wbeat_cnt = 0; rv_cnt = 0; first_cyc = -1;
    if (v.rw) begin
      beat = 0;
      k = 0;
      while (beat <= int'(v.len) && k < 64) begin
        wr_valid = v.gap ? (k % 2 == 0) : 1'b1;
        wr_data  = v.base + 8'(beat);
        @(negedge clk);
        if (wr_valid && wr_ready) begin
          a = v.addr + 8'(beat);
          exp_w.push_back({a, wr_data});
          ref_mem[a] = wr_data;
          beat++;
        end
        @(posedge clk); #1;
        k++;
      end
      wr_valid = 1'b0;
    end
    wait_busy_fall(fall_cyc);
    @(posedge clk); #1;
    check("busy_cycles", busy_cnt, v.exp_busy);
    check("first_beat_latency", first_cyc - acc_cyc, v.exp_lat);
    check("beat_count", v.rw ? wbeat_cnt : rv_cnt, v.exp_beats);
    if (!v.rw) check("busy_falls_with_last_rd", last_rv_cyc, fall_cyc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall_cyc, n_cs, rv_before;
    logic [7:0] a;
    logic [3:0] l;
    logic       g;
    for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i * 7 + 3);

    //            rw    addr   len   gap   base   busy lat beats
    vecs[0] = '{1'b1, 8'h10, 4'd3,  1'b0, 8'hA1, 4,  1, 4};
    vecs[1] = '{1'b0, 8'h10, 4'd3,  1'b0, 8'h00, 5,  2, 4};
    vecs[2] = '{1'b1, 8'hFE, 4'd3,  1'b1, 8'h30, 7,  1, 4};
    vecs[3] = '{1'b0, 8'hFE, 4'd3,  1'b0, 8'h00, 5,  2, 4};
    vecs[4] = '{1'b0, 8'h00, 4'd0,  1'b0, 8'h00, 2,  2, 1};
    vecs[5] = '{1'b1, 8'h80, 4'd15, 1'b0, 8'h00, 16, 1, 16};
    vecs[6] = '{1'b0, 8'h80, 4'd15, 1'b0, 8'h00, 17, 2, 16};
    vecs[7] = '{1'b1, 8'h05, 4'd0,  1'b1, 8'h77, 1,  1, 1};
    vecs[8] = '{1'b0, 8'h05, 4'd0,  1'b0, 8'h00, 2,  2, 1};
    a = 8'($urandom_range(0, 255));
    l = 4'($urandom_range(0, 15));
    g = 1'($urandom_range(0, 1));
    vecs[9]  = '{1'b1, a, l, g, 8'($urandom_range(0, 255)), g ? 2 * int'(l) + 1 : int'(l) + 1, 1, int'(l) + 1};
    vecs[10] = '{1'b0, a, l, 1'b0, 8'h00, int'(l) + 2, 2, int'(l) + 1};
    l = 4'($urandom_range(0, 15));
    vecs[11] = '{1'b0, 8'($urandom_range(0, 255)), l, 1'b0, 8'h00, int'(l) + 2, 2, int'(l) + 1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
    check("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_mem_oe", {31'd0, dut.mem_oe}, 32'd0);
    @(posedge clk); #3;
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_burst(vecs[i]);

    // Request held during a read burst with a different address
    wait_ready();
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h10; req_len = 4'd3;
    for (int i = 0; i < 4; i++) begin
      a = 8'h10 + 8'(i);
      exp_r.push_back(ref_mem[a]);
    end
    @(posedge clk); #1;
    req_addr = 8'h40; req_len = 4'd0;
    wait_busy_fall(fall_cyc);
    check("held_req_ready_at_fall", {31'd0, req_ready}, 32'd1);
    exp_r.push_back(ref_mem[8'h40]);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("held_req_accepted_after_fall", {31'd0, busy}, 32'd1);
    wait_busy_fall(fall_cyc);

    // Reset during beat 2 of a 16-beat read
    wait_ready();
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h20; req_len = 4'd15;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_reset_beat2_cs", {31'd0, mem_cs}, 32'd1);
    check("pre_reset_beat2_addr", {24'd0, mem_addr}, 32'h22);
    #1 reset = 1'b0;
    #1;
    check("abort_mem_cs", {31'd0, mem_cs}, 32'd0);
    check("abort_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("abort_mem_oe", {31'd0, dut.mem_oe}, 32'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    rv_before = rv_cnt;
    @(negedge clk);
    check("ready_after_release", {31'd0, req_ready}, 32'd1);
    n_cs = 0;
    repeat (20) begin
      @(negedge clk);
      n_cs += int'(mem_cs);
    end
    @(posedge clk); #1;
    check("no_cs_after_abort", n_cs, 0);
    check("no_rd_valid_after_abort", rv_cnt, rv_before);

    check("write_queue_drained", exp_w.size(), 0);
    check("read_queue_drained", exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
